face_search_ctrl: RTL and testbench

Sequencing controller for the 32x32 SAD engine in the face-finding accelerator. On a start command it raster-scans every candidate top-left position of a search range, issues one window per cycle to the SAD pipeline when window data is ready, and tags each issued window through a delay line matched to the engine latency. It compares each returned SAD against a running minimum and reports the best score and its position. It sits between the bus-side register file and the SAD engine / group-window buffer.

---
 rtl/face_search_ctrl_pkg.sv | 27 ++
 rtl/face_search_ctrl_if.sv | 35 +++
 rtl/face_search_ctrl_tag_pipe.sv | 35 +++
 rtl/face_search_ctrl.sv | 129 ++++++++++++
 tb/tb_face_search_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/face_search_ctrl_pkg.sv
// Shared types for the face-search controller: FSM encoding, tag record, defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package face_search_ctrl_pkg;

  localparam int DEF_SAD_LATENCY = 4;
  localparam int COORD_W         = 10;
  localparam int CNT_W           = 2*COORD_W + 1;

  localparam logic [31:0] SAD_INIT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // One tag per engine slot; valid=0 marks a bubble that must not be folded.
  typedef struct packed {
    logic               valid;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } tag_t;

  localparam tag_t TAG_NONE = '{valid: 1'b0, x: '0, y: '0};

endpackage

// File: rtl/face_search_ctrl_if.sv
// Bundle between register file / window buffer / SAD engine and the search controller.
// Latency: n/a (wires only).
// Backpressure: win_ready gates issue; the SAD result side never stalls.
interface face_search_ctrl_if;
  import face_search_ctrl_pkg::*;

  logic               start;
  logic [COORD_W-1:0] x_max;
  logic [COORD_W-1:0] y_max;
  logic               win_ready;
  logic [31:0]        sad;

  logic               issue;
  logic [COORD_W-1:0] issue_x;
  logic [COORD_W-1:0] issue_y;
  logic               busy;
  logic               done;
  logic [31:0]        best_sad;
  logic [COORD_W-1:0] best_x;
  logic [COORD_W-1:0] best_y;
  logic [CNT_W-1:0]   cand_cnt;

  // Controller side.
  modport slave (
    input  start, x_max, y_max, win_ready, sad,
    output issue, issue_x, issue_y, busy, done, best_sad, best_x, best_y, cand_cnt
  );

  // Register file / buffer / engine side.
  modport master (
    output start, x_max, y_max, win_ready, sad,
    input  issue, issue_x, issue_y, busy, done, best_sad, best_x, best_y, cand_cnt
  );

endinterface

// File: rtl/face_search_ctrl_tag_pipe.sv
// sad_tag_pipe: DEPTH-stage tag shift register aligned to the SAD engine, plus any-valid flag.
// Latency: DEPTH cycles from push_tag to pop_tag.
// Backpressure: none; shifts every cycle, synchronous clear drops all in-flight tags.
module sad_tag_pipe
  import face_search_ctrl_pkg::*;
#(
  parameter int DEPTH = DEF_SAD_LATENCY
) (
  input  logic clk,
  input  logic clr,
  input  tag_t push_tag,
  output tag_t pop_tag,
  output logic any_vld
);

  tag_t stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= TAG_NONE;
    end else begin
      stage_q[0] <= push_tag;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign pop_tag = stage_q[DEPTH-1];

  // DRAIN may only finish once every slot, not just the output one, is empty.
  always_comb begin
    any_vld = 1'b0;
    for (int i = 0; i < DEPTH; i++) any_vld = any_vld | stage_q[i].valid;
  end

endmodule

// File: rtl/face_search_ctrl.sv
// Raster-scan sequencer for the SAD engine; tracks min SAD and its position.
// Latency: result of issue in cycle t folded at end of t+SAD_LATENCY; done at N+SAD_LATENCY+1.
// Backpressure: issue only when win_ready; engine results are never stalled.
// Ports: Bus2IP_Clk/Bus2IP_Resetn (sync active-low), bus = face_search_ctrl_if.slave.
module face_search_ctrl
  import face_search_ctrl_pkg::*;
#(
  parameter int SAD_LATENCY = DEF_SAD_LATENCY
) (
  input  logic                Bus2IP_Clk,
  input  logic                Bus2IP_Resetn,
  face_search_ctrl_if.slave   bus
);

  state_t             state_q, state_d;
  logic [COORD_W-1:0] x_max_q, y_max_q;
  logic [COORD_W-1:0] x_q, y_q;
  logic [COORD_W-1:0] best_x_q, best_y_q;
  logic [31:0]        best_sad_q;
  logic [CNT_W-1:0]   cand_cnt_q;

  logic issue, busy, done;
  logic start_ok, x_at_max, last_issue;
  logic any_vld;
  tag_t push_tag, pop_tag;

  assign start_ok   = (state_q == ST_IDLE) && bus.start;
  assign x_at_max   = (x_q == x_max_q);
  assign last_issue = issue && x_at_max && (y_q == y_max_q);
  assign push_tag   = '{valid: issue, x: x_q, y: y_q};

  // State register.
  always_ff @(posedge Bus2IP_Clk) begin
    if (!Bus2IP_Resetn) state_q <= ST_IDLE;
    else                state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start)  state_d = ST_RUN;
      ST_RUN:   if (last_issue) state_d = ST_DRAIN;
      ST_DRAIN: if (!any_vld)   state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    issue = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      ST_RUN: begin
        issue = bus.win_ready;
        busy  = 1'b1;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        done = !any_vld;
      end
      default: ;
    endcase
  end

  // Position counters and min-fold. Reset wins over the fold so stale
  // engine outputs from an aborted scan are never accumulated.
  always_ff @(posedge Bus2IP_Clk) begin
    if (!Bus2IP_Resetn) begin
      x_max_q    <= '0;
      y_max_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      best_sad_q <= SAD_INIT;
      best_x_q   <= '0;
      best_y_q   <= '0;
      cand_cnt_q <= '0;
    end else if (start_ok) begin
      x_max_q    <= bus.x_max;
      y_max_q    <= bus.y_max;
      x_q        <= '0;
      y_q        <= '0;
      best_sad_q <= SAD_INIT;
      best_x_q   <= '0;
      best_y_q   <= '0;
      cand_cnt_q <= '0;
    end else begin
      if (issue) begin
        if (x_at_max) begin
          x_q <= '0;
          y_q <= y_q + COORD_W'(1);
        end else begin
          x_q <= x_q + COORD_W'(1);
        end
      end
      if (pop_tag.valid) begin
        cand_cnt_q <= cand_cnt_q + CNT_W'(1);
        // Strict compare: on a tie the earlier raster position is kept.
        if (bus.sad < best_sad_q) begin
          best_sad_q <= bus.sad;
          best_x_q   <= pop_tag.x;
          best_y_q   <= pop_tag.y;
        end
      end
    end
  end

  sad_tag_pipe #(
    .DEPTH (SAD_LATENCY)
  ) u_tag_pipe (
    .clk      (Bus2IP_Clk),
    .clr      (~Bus2IP_Resetn),
    .push_tag (push_tag),
    .pop_tag  (pop_tag),
    .any_vld  (any_vld)
  );

  assign bus.issue    = issue;
  assign bus.issue_x  = x_q;
  assign bus.issue_y  = y_q;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.best_sad = best_sad_q;
  assign bus.best_x   = best_x_q;
  assign bus.best_y   = best_y_q;
  assign bus.cand_cnt = cand_cnt_q;

endmodule

// File: tb/tb_face_search_ctrl.sv
// Directed bench for face_search_ctrl with a 4-cycle SAD engine model.
// Latency: engine model returns sad SAD_LATENCY cycles after issue.
// Backpressure: win_ready driven per scenario (constant or toggling).
module tb_face_search_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  face_search_ctrl_if bus();

  face_search_ctrl #(.SAD_LATENCY(4)) dut (
    .Bus2IP_Clk    (clk),
    .Bus2IP_Resetn (rst_n),
    .bus           (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // SAD value table: default plus up to two special positions.
  logic [31:0] sad_dflt = 32'd100;
  bit          s1_en = 1'b0, s2_en = 1'b0;
  int          s1x, s1y, s2x, s2y;
  logic [31:0] s1v, s2v;

  function automatic logic [31:0] sad_of(input logic [9:0] x, input logic [9:0] y);
    if (s1_en && x == 10'(s1x) && y == 10'(s1y)) return s1v;
    if (s2_en && x == 10'(s2x) && y == 10'(s2y)) return s2v;
    return sad_dflt;
  endfunction

  // Engine model: window issued in cycle t yields sad in cycle t+4; bubbles give garbage.
  logic [31:0] eng [4];
  always @(posedge clk) begin
    eng[0] <= bus.issue ? sad_of(bus.issue_x, bus.issue_y) : 32'h0000_0001;
    for (int i = 1; i < 4; i++) eng[i] <= eng[i-1];
  end
  assign bus.sad = eng[3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one scan from a start pulse (accepted at edge 0); cycle c follows edge c.
  task automatic run_scan(input int xm, input int ym, input bit toggle,
                          input int inj1, input int inj2,
                          output int done_cyc, output int n_done,
                          output int order_err, output logic busy_after);
    int n, issued, ex, ey;
    bit wr, exp_issue;
    n = (xm + 1) * (ym + 1);
    issued = 0; ex = 0; ey = 0;
    done_cyc = -1; n_done = 0; order_err = 0; busy_after = 1'bx;
    @(posedge clk); #1;
    bus.x_max = 10'(xm); bus.y_max = 10'(ym); bus.start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 400; c++) begin
      wr = toggle ? c[0] : 1'b1;
      bus.win_ready = wr;
      if (c == inj1 || c == inj2) begin
        bus.start = 1'b1; bus.x_max = 10'd7;
      end else begin
        bus.start = 1'b0; bus.x_max = 10'(xm);
      end
      @(negedge clk);
      exp_issue = wr && (issued < n);
      if (bus.issue !== exp_issue) order_err++;
      if (issued < n && (bus.issue_x !== 10'(ex) || bus.issue_y !== 10'(ey))) order_err++;
      if (exp_issue) begin
        issued++;
        if (ex == xm) begin ex = 0; ey++; end
        else ex++;
      end
      if (bus.done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc > 0 && c == done_cyc + 1) busy_after = bus.busy;
      if (done_cyc > 0 && c >= done_cyc + 3) break;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.x_max = 10'(xm);
  endtask

  int dc, nd, oe, nd_rst, cnt_moves;
  logic ba;

  initial begin
    bus.start = 1'b0; bus.x_max = '0; bus.y_max = '0; bus.win_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_issue",    bus.issue,    0);
    chk("rst_busy",     bus.busy,     0);
    chk("rst_done",     bus.done,     0);
    chk("rst_issue_x",  bus.issue_x,  0);
    chk("rst_issue_y",  bus.issue_y,  0);
    chk("rst_best_sad", bus.best_sad, 32'hFFFF_FFFF);
    chk("rst_best_x",   bus.best_x,   0);
    chk("rst_best_y",   bus.best_y,   0);
    chk("rst_cand_cnt", bus.cand_cnt, 0);
    rst_n = 1'b1;

    // Minimal scan: single candidate, sad 37.
    sad_dflt = 32'd37; s1_en = 1'b0; s2_en = 1'b0;
    run_scan(0, 0, 1'b0, 0, 0, dc, nd, oe, ba);
    chk("min_done_cyc", dc, 6);
    chk("min_n_done",   nd, 1);
    chk("min_order",    oe, 0);
    chk("min_busy_fall", ba, 0);
    chk("min_best_sad", bus.best_sad, 37);
    chk("min_best_xy",  {bus.best_x, bus.best_y}, 0);
    chk("min_cand",     bus.cand_cnt, 1);

    // 4x3 scan, minimum 12 at (2,1).
    sad_dflt = 32'd100; s1_en = 1'b1; s1x = 2; s1y = 1; s1v = 32'd12;
    run_scan(3, 2, 1'b0, 0, 0, dc, nd, oe, ba);
    chk("4x3_done_cyc", dc, 17);
    chk("4x3_n_done",   nd, 1);
    chk("4x3_order",    oe, 0);
    chk("4x3_busy_fall", ba, 0);
    chk("4x3_best_sad", bus.best_sad, 12);
    chk("4x3_best_x",   bus.best_x, 2);
    chk("4x3_best_y",   bus.best_y, 1);
    chk("4x3_cand",     bus.cand_cnt, 12);

    // Tie: 5 at (1,0) and (3,2); earlier position wins.
    s1x = 1; s1y = 0; s1v = 32'd5; s2_en = 1'b1; s2x = 3; s2y = 2; s2v = 32'd5;
    run_scan(3, 2, 1'b0, 0, 0, dc, nd, oe, ba);
    chk("tie_best_sad", bus.best_sad, 5);
    chk("tie_best_x",   bus.best_x, 1);
    chk("tie_best_y",   bus.best_y, 0);
    chk("tie_cand",     bus.cand_cnt, 12);

    // Backpressure: win_ready toggles 1,0; done 11 cycles later than 17.
    s2_en = 1'b0; s1x = 2; s1y = 1; s1v = 32'd12;
    run_scan(3, 2, 1'b1, 0, 0, dc, nd, oe, ba);
    chk("bp_done_cyc", dc, 28);
    chk("bp_n_done",   nd, 1);
    chk("bp_order",    oe, 0);
    chk("bp_best_sad", bus.best_sad, 12);
    chk("bp_best_x",   bus.best_x, 2);
    chk("bp_best_y",   bus.best_y, 1);
    chk("bp_cand",     bus.cand_cnt, 12);

    // Reset mid-scan after 5 issues; small stale sad would win if folded.
    sad_dflt = 32'd3; s1_en = 1'b0;
    @(posedge clk); #1;
    bus.x_max = 10'd3; bus.y_max = 10'd2; bus.start = 1'b1; bus.win_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_busy",     bus.busy, 0);
    chk("mrst_issue",    bus.issue, 0);
    chk("mrst_done",     bus.done, 0);
    chk("mrst_issue_xy", {bus.issue_x, bus.issue_y}, 0);
    chk("mrst_best_sad", bus.best_sad, 32'hFFFF_FFFF);
    chk("mrst_best_xy",  {bus.best_x, bus.best_y}, 0);
    chk("mrst_cand",     bus.cand_cnt, 0);
    nd_rst = 0; cnt_moves = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) nd_rst++;
      if (bus.cand_cnt !== '0 || bus.best_sad !== 32'hFFFF_FFFF) cnt_moves++;
    end
    chk("mrst_no_done", nd_rst, 0);
    chk("mrst_no_fold", cnt_moves, 0);
    sad_dflt = 32'd100; s1_en = 1'b1; s1x = 1; s1y = 1; s1v = 32'd9;
    run_scan(1, 1, 1'b0, 0, 0, dc, nd, oe, ba);
    chk("post_done_cyc", dc, 9);
    chk("post_order",    oe, 0);
    chk("post_best_sad", bus.best_sad, 9);
    chk("post_best_xy",  {bus.best_x, bus.best_y}, {10'd1, 10'd1});
    chk("post_cand",     bus.cand_cnt, 4);

    // Start pulses in RUN (cycle 5) and DRAIN (cycle 14) with x_max=7 are ignored.
    s1x = 2; s1y = 1; s1v = 32'd12;
    run_scan(3, 2, 1'b0, 5, 14, dc, nd, oe, ba);
    chk("sib_done_cyc", dc, 17);
    chk("sib_n_done",   nd, 1);
    chk("sib_order",    oe, 0);
    chk("sib_best_x",   bus.best_x, 2);
    chk("sib_best_y",   bus.best_y, 1);
    chk("sib_cand",     bus.cand_cnt, 12);
    chk("sib_idle",     bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
